multicycle_ctrl_fsm: RTL

- Fetch/decode/sequencing controller for the 16-bit multicycle RISC.
- Sits directly upstream of the register-file-plus-ALU datapath.
- Holds the instruction register (`Ins`) and steps each instruction through FETCH/ID/EXE/MEM/WB.
- Drives every datapath control strobe per state, plus the instruction- and data-memory handshakes.

---
 rtl/risc_ctrl_pkg.sv | 65 ++++++
 rtl/ctrl_decode.sv | 108 ++++++++++
 rtl/multicycle_ctrl_fsm.sv | 107 ++++++++++
 3 files changed

// File: rtl/risc_ctrl_pkg.sv
// rtl/risc_ctrl_pkg.sv - states, opcodes, ALU codes and control-vector type for the multicycle controller
package risc_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_FETCH = 3'd0;
    localparam state_t ST_ID    = 3'd1;
    localparam state_t ST_EXE   = 3'd2;
    localparam state_t ST_MEM   = 3'd3;
    localparam state_t ST_WB    = 3'd4;
    localparam state_t ST_HALT  = 3'd5;

    localparam logic [4:0] OP_LHI    = 5'b00001;
    localparam logic [4:0] OP_LLI    = 5'b00010;
    localparam logic [4:0] OP_LDR_RI = 5'b00011;
    localparam logic [4:0] OP_LDR_RR = 5'b00100;
    localparam logic [4:0] OP_STR_RI = 5'b00101;
    localparam logic [4:0] OP_STR_RR = 5'b00110;
    localparam logic [4:0] OP_ADD    = 5'b00111;
    localparam logic [4:0] OP_ADC    = 5'b01000;
    localparam logic [4:0] OP_SUB    = 5'b01001;
    localparam logic [4:0] OP_SBB    = 5'b01010;
    localparam logic [4:0] OP_CMP    = 5'b01011;
    localparam logic [4:0] OP_ADDI   = 5'b01100;
    localparam logic [4:0] OP_SUBI   = 5'b01101;

    // {PSW_C, ALUop, Flag}
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_ADC = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_SBB = 3'b011;

    // How the state advances toward the decoded target
    localparam logic [1:0] NS_GO   = 2'd0;
    localparam logic [1:0] NS_IMEM = 2'd1;
    localparam logic [1:0] NS_DMEM = 2'd2;
    localparam logic [1:0] NS_STAY = 2'd3;

    typedef struct packed {
        logic imem_rd;
        logic wbrf;
        logic wbresource;
        logic rbresource;
        logic oprandb;
        logic li;
        logic buff_idexe;
        logic psw_c;
        logic aluop;
        logic flag;
        logic psw_we;
        logic dmem_rd;
        logic dmem_wr;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic logic is_load(input logic [4:0] op);
        return (op == OP_LDR_RI) || (op == OP_LDR_RR);
    endfunction

    function automatic logic is_store(input logic [4:0] op);
        return (op == OP_STR_RI) || (op == OP_STR_RR);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational (state, opcode) to control vector and next-state class
module ctrl_decode
    import risc_ctrl_pkg::*;
(
    input  logic [2:0]        state,
    input  logic [4:0]        opcode,
    output logic [CTRL_W-1:0] ctrl,
    output logic [1:0]        ns_class,
    output logic [2:0]        ns_target,
    output logic              undef
);

    ctrl_t c;

    always_comb begin
        c         = '0;
        ns_class  = NS_GO;
        ns_target = ST_FETCH;
        undef     = 1'b0;
        case (state)
            ST_FETCH: begin
                c.imem_rd = 1'b1;
                ns_class  = NS_IMEM;
                ns_target = ST_ID;
            end
            ST_ID: begin
                c.buff_idexe = 1'b1;
                ns_target    = ST_EXE;
                case (opcode)
                    OP_LHI: begin
                        c.rbresource = 1'b1;
                        ns_target    = ST_WB;
                    end
                    OP_LLI: begin
                        c.li      = 1'b1;
                        ns_target = ST_WB;
                    end
                    OP_LDR_RI, OP_STR_RI, OP_ADDI, OP_SUBI: c.oprandb = 1'b1;
                    OP_LDR_RR, OP_STR_RR, OP_ADD, OP_ADC,
                    OP_SUB, OP_SBB, OP_CMP: c.oprandb = 1'b0;
                    default: begin
                        undef     = 1'b1;
                        ns_target = ST_FETCH;
                    end
                endcase
            end
            ST_EXE: begin
                ns_target = ST_WB;
                case (opcode)
                    OP_ADD, OP_ADDI: begin
                        {c.psw_c, c.aluop, c.flag} = ALU_ADD;
                        c.psw_we = 1'b1;
                    end
                    OP_ADC: begin
                        {c.psw_c, c.aluop, c.flag} = ALU_ADC;
                        c.psw_we = 1'b1;
                    end
                    OP_SUB, OP_SUBI: begin
                        {c.psw_c, c.aluop, c.flag} = ALU_SUB;
                        c.psw_we = 1'b1;
                    end
                    OP_SBB: begin
                        {c.psw_c, c.aluop, c.flag} = ALU_SBB;
                        c.psw_we = 1'b1;
                    end
                    OP_CMP: begin
                        {c.psw_c, c.aluop, c.flag} = ALU_SUB;
                        c.psw_we  = 1'b1;
                        ns_target = ST_FETCH;
                    end
                    OP_LDR_RI, OP_LDR_RR: begin
                        {c.psw_c, c.aluop, c.flag} = ALU_ADD;
                        ns_target = ST_MEM;
                    end
                    OP_STR_RI, OP_STR_RR: begin
                        {c.psw_c, c.aluop, c.flag} = ALU_ADD;
                        c.rbresource = 1'b1;
                        ns_target    = ST_MEM;
                    end
                    default: ns_target = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (is_load(opcode)) begin
                    c.dmem_rd = 1'b1;
                    ns_class  = NS_DMEM;
                    ns_target = ST_WB;
                end else if (is_store(opcode)) begin
                    c.dmem_wr    = 1'b1;
                    c.rbresource = 1'b1;
                    ns_class     = NS_DMEM;
                end
            end
            ST_WB: begin
                c.wbrf       = 1'b1;
                c.wbresource = !is_load(opcode);
            end
            ST_HALT: begin
                ns_class  = NS_STAY;
                ns_target = ST_HALT;
            end
            default: ns_target = ST_FETCH;
        endcase
    end

    assign ctrl = c;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - fetch/decode/sequencing controller; CTRL_ILLEGAL_TRAP_EN enables the illegal-opcode trap
module multicycle_ctrl_fsm
    import risc_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [15:0] IMem_data,
    input  logic        IMem_ready,
    input  logic        DMem_ready,
    output logic [15:0] PC,
    output logic        IMem_rd,
    output logic [15:0] Ins,
    output logic        WBRF,
    output logic        WBresource,
    output logic        RBresource,
    output logic        OprandB,
    output logic        LI,
    output logic        Buff_IDEXE,
    output logic        PSW_C,
    output logic        ALUop,
    output logic        Flag,
    output logic        PSW_we,
    output logic        DMem_rd,
    output logic        DMem_wr,
    output logic        Illegal
);

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    state_t            state;
    state_t            state_n;
    logic [CTRL_W-1:0] ctrl_bits;
    logic [1:0]        ns_class;
    logic [2:0]        ns_target;
    logic              undef;
    logic              trap;
    logic              advance;
    logic              illegal_q;
    ctrl_t             c;

    ctrl_decode u_decode (
        .state     (state),
        .opcode    (Ins[15:11]),
        .ctrl      (ctrl_bits),
        .ns_class  (ns_class),
        .ns_target (ns_target),
        .undef     (undef)
    );

    assign trap = undef & TRAP_EN;

    always_comb begin
        case (ns_class)
            NS_IMEM: advance = IMem_ready;
            NS_DMEM: advance = DMem_ready;
            NS_STAY: advance = 1'b0;
            default: advance = 1'b1;
        endcase
        if (trap)
            state_n = ST_HALT;
        else if (advance)
            state_n = ns_target;
        else
            state_n = state;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= ST_FETCH;
            PC        <= RESET_PC;
            Ins       <= 16'h0000;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_n;
            illegal_q <= illegal_q | trap;
            if (state == ST_FETCH && IMem_ready) begin
                Ins <= IMem_data;
                PC  <= PC + 16'd1;
            end
        end
    end

    // Strobes are forced low while Reset is asserted so an aborted instruction emits nothing
    assign c = Reset ? '0 : ctrl_t'(ctrl_bits);

    assign IMem_rd    = c.imem_rd;
    assign WBRF       = c.wbrf;
    assign WBresource = c.wbresource;
    assign RBresource = c.rbresource;
    assign OprandB    = c.oprandb;
    assign LI         = c.li;
    assign Buff_IDEXE = c.buff_idexe;
    assign PSW_C      = c.psw_c;
    assign ALUop      = c.aluop;
    assign Flag       = c.flag;
    assign PSW_we     = c.psw_we;
    assign DMem_rd    = c.dmem_rd;
    assign DMem_wr    = c.dmem_wr;
    assign Illegal    = illegal_q;

endmodule
